// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition mnemonics and NZCV flag layout
package cond_pkg;

  localparam int NZCV_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_eval_unit_if.sv
// rtl/cond_eval_unit_if.sv - ID/EXE condition-evaluation bundle; master is the pipeline, slave the unit
interface cond_eval_unit_if #(
  parameter int NUM_SLOTS = 1,
  parameter int CNT_W     = 16
);
  import cond_pkg::*;

  logic                   flag_we;
  logic [NZCV_W-1:0]      flag_in;
  logic                   stall;
  logic                   flush;
  logic [NUM_SLOTS-1:0]   in_valid;
  logic [4*NUM_SLOTS-1:0] cond_in;
  logic [NUM_SLOTS-1:0]   out_valid;
  logic [NUM_SLOTS-1:0]   cond_pass;
  logic [NUM_SLOTS-1:0]   cond_illegal;
  logic [NZCV_W-1:0]      flags_out;
  logic [CNT_W-1:0]       squash_cnt;

  modport master (
    output flag_we, flag_in, stall, flush, in_valid, cond_in,
    input  out_valid, cond_pass, cond_illegal, flags_out, squash_cnt
  );

  modport slave (
    input  flag_we, flag_in, stall, flush, in_valid, cond_in,
    output out_valid, cond_pass, cond_illegal, flags_out, squash_cnt
  );

endinterface

// File: rtl/cond_decode.sv
// rtl/cond_decode.sv - combinational ARM condition-field evaluator for one slot
module cond_decode
  import cond_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [NZCV_W-1:0] flags,
  output logic              pass,
  output logic              illegal
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass    = 1'b0;
    illegal = 1'b0;
    case (cond)
      EQ: pass = z;
      NE: pass = ~z;
      CS: pass = c;
      CC: pass = ~c;
      MI: pass = n;
      PL: pass = ~n;
      VS: pass = v;
      VC: pass = ~v;
      HI: pass = c & ~z;
      LS: pass = ~c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = ~z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      // reserved code never commits and is flagged instead
      NV: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_eval_unit.sv
// rtl/cond_eval_unit.sv - NZCV status register plus registered multi-slot condition evaluation
// Optional same-cycle flag forwarding: COND_FLAG_BYPASS_EN
module cond_eval_unit
  import cond_pkg::*;
#(
  parameter int NUM_SLOTS = 1,
  parameter int CNT_W     = 16
) (
  input logic              clk,
  input logic              rst,
  cond_eval_unit_if.slave  bus
);

  logic [NZCV_W-1:0]    flags_q;
  logic [NZCV_W-1:0]    eval_flags;
  logic [NUM_SLOTS-1:0] eval;
  logic [NUM_SLOTS-1:0] illegal;
  logic [NUM_SLOTS-1:0] valid_q;
  logic [NUM_SLOTS-1:0] pass_q;
  logic [NUM_SLOTS-1:0] illegal_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           nfail;
  logic [CNT_W:0]       cnt_sum;
  logic [CNT_W-1:0]     cnt_next;

`ifdef COND_FLAG_BYPASS_EN
  assign eval_flags = bus.flag_we ? bus.flag_in : flags_q;
`else
  assign eval_flags = flags_q;
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    cond_decode u_decode (
      .cond    (bus.cond_in[4*i +: 4]),
      .flags   (eval_flags),
      .pass    (eval[i]),
      .illegal (illegal[i])
    );
  end

  always_comb begin
    nfail = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      nfail = nfail + 3'(bus.in_valid[s] & ~eval[s]);
    end
  end

  // one spare bit catches the overflow so the counter clamps instead of wrapping
  assign cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(nfail);
  assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (bus.flag_we) begin
      flags_q <= bus.flag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      pass_q    <= '0;
      illegal_q <= '0;
      cnt_q     <= '0;
    end else if (bus.flush) begin
      valid_q   <= '0;
      pass_q    <= '0;
      illegal_q <= '0;
    end else if (!bus.stall) begin
      valid_q   <= bus.in_valid;
      pass_q    <= bus.in_valid & eval;
      illegal_q <= bus.in_valid & illegal;
      cnt_q     <= cnt_next;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.cond_pass    = pass_q;
  assign bus.cond_illegal = illegal_q;
  assign bus.flags_out    = flags_q;
  assign bus.squash_cnt   = cnt_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// tb/tb_cond_eval_unit.sv - scoreboard bench for cond_eval_unit, two slots, 4-bit squash counter
module tb_cond_eval_unit;

  localparam int NS    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [NS-1:0] valid;
    logic [NS-1:0] pass;
    logic [NS-1:0] ill;
    logic [3:0]    flags;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  logic [NS-1:0] m_valid, m_pass, m_ill;
  logic [3:0]    m_flags;
  int            m_cnt;

  cond_eval_unit_if #(.NUM_SLOTS(NS), .CNT_W(CW)) bus ();

  cond_eval_unit #(.NUM_SLOTS(NS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] & ~f[2];
      3'd5: b = (f[3] == f[0]);
      3'd6: b = ~f[2] & (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    if (c[0]) return ~b;
    return b;
  endfunction

  task automatic cycle(input logic r, input logic we, input logic [3:0] fin,
                       input logic stl, input logic fl,
                       input logic [NS-1:0] vld, input logic [4*NS-1:0] cnd);
    logic [3:0] f;
    exp_t e, got;
    @(negedge clk);
    rst = r; bus.flag_we = we; bus.flag_in = fin; bus.stall = stl;
    bus.flush = fl; bus.in_valid = vld; bus.cond_in = cnd;
    f = m_flags;
`ifdef COND_FLAG_BYPASS_EN
    if (we) f = fin;
`endif
    if (r) begin
      m_flags = '0; m_valid = '0; m_pass = '0; m_ill = '0; m_cnt = 0;
    end else begin
      if (we) m_flags = fin;
      if (fl) begin
        m_valid = '0; m_pass = '0; m_ill = '0;
      end else if (!stl) begin
        for (int s = 0; s < NS; s++) begin
          logic [3:0] c;
          c = cnd[4*s +: 4];
          m_valid[s] = vld[s];
          m_pass[s]  = vld[s] & ref_eval(c, f);
          m_ill[s]   = vld[s] & (c == 4'hF);
          if (vld[s] && !ref_eval(c, f)) m_cnt = m_cnt + 1;
        end
        if (m_cnt > CMAX) m_cnt = CMAX;
      end
    end
    e.valid = m_valid; e.pass = m_pass; e.ill = m_ill;
    e.flags = m_flags; e.cnt = CW'(m_cnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'(got.valid));
      check("cond_pass", 32'(bus.cond_pass), 32'(got.pass));
      check("cond_illegal", 32'(bus.cond_illegal), 32'(got.ill));
      check("flags_out", 32'(bus.flags_out), 32'(got.flags));
      check("squash_cnt", 32'(bus.squash_cnt), 32'(got.cnt));
    end
  endtask

  initial begin
    m_flags = '0; m_valid = '0; m_pass = '0; m_ill = '0; m_cnt = 0;
    rst = 1'b1; bus.flag_we = 1'b0; bus.flag_in = '0; bus.stall = 1'b0;
    bus.flush = 1'b0; bus.in_valid = '0; bus.cond_in = '0;

    cycle(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 2'b11, 8'h0E);
    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hEE);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'(bus.flags_out), 32'd0);
    check("rst_cnt", 32'(bus.squash_cnt), 32'd0);

    cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 2'b00, 8'h00);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b11, {4'h1, 4'h0});
    check("ne_eq_pass", 32'(bus.cond_pass), 32'b01);
    check("ne_eq_cnt", 32'(bus.squash_cnt), 32'd1);

    for (int f = 0; f < 16; f++) begin
      cycle(1'b0, 1'b1, 4'(f), 1'b0, 1'b0, 2'b00, 8'h00);
      for (int c = 0; c < 16; c++) begin
        logic [3:0] c1;
        logic       v1;
        c1 = 4'($urandom_range(15));
        v1 = 1'($urandom_range(1));
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, {v1, 1'b1}, {c1, 4'(c)});
        if (c == 15) check("nv_illegal", 32'({bus.cond_illegal[0], bus.cond_pass[0]}), 32'b10);
        if (c == 14) check("al_pass", 32'(bus.cond_pass[0]), 32'd1);
      end
    end

    cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 2'b00, 8'h00);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b11, {4'hF, 4'h0});
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 2'($urandom_range(3)), 8'($urandom));
    end
    check("stall_hold_pass", 32'(bus.cond_pass), 32'b01);
    check("stall_hold_ill", 32'(bus.cond_illegal), 32'b10);
    cycle(1'b0, 1'b1, 4'b1001, 1'b1, 1'b1, 2'b11, 8'hEE);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_flags", 32'(bus.flags_out), 32'b1001);

    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00);
    cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 2'b01, 8'h00);
`ifdef COND_FLAG_BYPASS_EN
    check("bypass_pass", 32'(bus.cond_pass[0]), 32'd1);
`else
    check("bypass_pass", 32'(bus.cond_pass[0]), 32'd0);
`endif

    cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b01, 8'h00);
    end
    check("sat_16", 32'(bus.squash_cnt), 32'hF);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'h00);
    cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 2'b11, 8'hFF);
    check("sat_hold", 32'(bus.squash_cnt), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_eval_unit.md
Name: cond_eval_unit

Overview:
- Parametrised successor to the single-lane condition checker.
- Owns the architectural NZCV status register and evaluates the ARM 4-bit condition field for NUM_SLOTS instructions per cycle.
- Registers the result for one cycle, with stall/flush handshake, illegal-condition reporting and a saturating squash counter.
- Sits between ID/EXE: flags are written from EXE, conditions are evaluated for instructions entering EXE.

Parameters:
- NUM_SLOTS, 1, number of instructions evaluated per cycle (1..4).
- CNT_W, 16, width of the squashed-instruction performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flag_we  in  1  write status register this cycle (S-bit instruction in EXE).
- flag_in  in  4  new flags {N,Z,C,V}, bit 3 = N.
- stall  in  1  hold all output registers.
- flush  in  1  invalidate all slot outputs.
- in_valid  in  NUM_SLOTS  slot i carries a valid instruction.
- cond_in  in  4*NUM_SLOTS  condition field; slot i at [4i+3:4i].
- out_valid  out  NUM_SLOTS  registered copy of in_valid.
- cond_pass  out  NUM_SLOTS  slot i condition true; instruction may commit.
- cond_illegal  out  NUM_SLOTS  slot i used reserved code 4'b1111.
- flags_out  out  4  current status register contents.
- squash_cnt  out  CNT_W  count of valid instructions whose condition failed.

Behaviour:
- Reset (rst=1 at edge):
  - flags_out = 0, out_valid = 0, cond_pass = 0, cond_illegal = 0, squash_cnt = 0.
  - rst overrides all other inputs.
- Status register:
  - If flag_we, flags_out <= flag_in at the edge.
  - Independent of stall and flush; the producer gates flag_we.
- Evaluation flags F:
  - F = flags_out, i.e. the value before this edge's write.
  - Exception: see FLAG_BYPASS_EN under Optional Feature.
- Condition table:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1.
  - 1111: eval = 0 and illegal = 1. Never X or Z.
- Output register update priority: rst > flush > stall > normal.
  - flush: out_valid = 0, cond_pass = 0, cond_illegal = 0.
  - stall: all slot outputs hold their values.
  - normal: out_valid[i] <= in_valid[i]; cond_pass[i] <= in_valid[i] & eval_i; cond_illegal[i] <= in_valid[i] & (cond_i==4'b1111).
- Latency: 1 cycle, cond_in to cond_pass.
- Invalid slots always produce pass = 0 and illegal = 0.
- squash_cnt:
  - Applies only on normal cycles (no rst, flush or stall).
  - Adds the number of slots with in_valid & !eval, 0..NUM_SLOTS, in the same cycle.
  - Saturates at 2^CNT_W-1; never wraps. If the sum would exceed the maximum, the result is clamped.
  - An illegal code counts as squashed.
- Simultaneous events:
  - flag_we with flush: flags are written and outputs are cleared.
  - flag_we with stall: flags are written; outputs hold and are not re-evaluated.
- All slots in a cycle see the same F; there are no intra-bundle flag dependencies.

Optional Feature:
- Macro: COND_FLAG_BYPASS_EN.
- Defined: when flag_we=1, F = flag_in, so a same-cycle flag write is forwarded into the evaluation. Adds a 4-bit mux in the flag_in -> cond_pass path.
- Undefined: F is always flags_out; the hazard unit must stall one cycle after an S-bit instruction.
- Status register behaviour is identical in both builds.

Decomposition:
- Shared package cond_pkg:
  - cond_e enum of 16 mnemonics (EQ..AL, NV=4'b1111).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - NZCV_W=4.
- Sub-module cond_decode:
  - Purely combinational; inputs cond and flags, outputs pass and illegal.
  - Instantiated NUM_SLOTS times via generate.
- Top level holds the status register, output registers and the counter.

Test Plan:
- Reset, NUM_SLOTS=2: rst=1 for 2 cycles with in_valid=2'b11 -> all outputs 0; flags_out=0; squash_cnt=0.
- Write flags_in=4'b0100 (Z=1), then next cycle cond_in={NE,EQ}, in_valid=11 -> one cycle later cond_pass=2'b01, squash_cnt=1.
- Sweep all 16 codes against all 16 flag combinations, slot 0:
  - pass matches the table.
  - Code 1111 gives pass=0 and illegal=1.
  - AL passes for every flag value.
- Stall and flush:
  - Stall for 3 cycles with changing cond_in -> outputs hold.
  - Then flush=stall=1 -> out_valid=0.
  - flag_we=1, flag_in=4'b1001 in the flush cycle -> flags_out=4'b1001.
- Bypass:
  - flags_out=0, flag_we=1, flag_in=4'b0100, cond_in=EQ.
  - With COND_FLAG_BYPASS_EN: pass=1. Without it: pass=0.
- Saturation, CNT_W=4: force 16 failing conditions, then 2 more with both slots failing -> squash_cnt stays at 4'hF.
